// File: rtl/cpu_register_dump.sv
// Sequential register-file reader: walks [first..last] (wrapping) on one read port, streams words out valid/ready.
// Optional macro CPU_REGISTER_DUMP_SKIP_ZERO_EN suppresses the hardwired-zero register at address 0.
module cpu_register_dump #(
    parameter int NUMBER_OF_REGISTERS = 256,
    parameter int DATA_WIDTH          = 8,
    localparam int AW                 = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [AW-1:0]         first_address_in,
    input  logic [AW-1:0]         last_address_in,
    output logic [AW-1:0]         read_register_address_out,
    input  logic [DATA_WIDTH-1:0] read_data_in,
    output logic                  dump_valid_out,
    input  logic                  dump_ready_in,
    output logic [DATA_WIDTH-1:0] dump_data_out,
    output logic [AW-1:0]         dump_address_out,
    output logic                  dump_last_out,
    output logic                  busy_out,
    output logic                  done_out
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           cur_addr_q, cur_addr_d;
    logic [AW-1:0]           end_addr_q, end_addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic                    last_q, last_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        if (a == AW'(NUMBER_OF_REGISTERS - 1)) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

`ifdef CPU_REGISTER_DUMP_SKIP_ZERO_EN
    // A beat is final if it ends the range, or if the only address left is the skipped zero.
    logic final_beat;
    assign final_beat = (cur_addr_q == end_addr_q) ||
                        ((end_addr_q == '0) && (next_addr(cur_addr_q) == '0));
`endif

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        data_d     = data_q;
        addr_d     = addr_q;
        last_d     = last_q;
        valid_d    = valid_q;

        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    cur_addr_d = first_address_in;
                    end_addr_d = last_address_in;
                    state_d    = READ;
                end
            end
            READ: begin
                if (abort_in) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else begin
`ifdef CPU_REGISTER_DUMP_SKIP_ZERO_EN
                    if (cur_addr_q == '0) begin
                        if (cur_addr_q == end_addr_q) begin
                            state_d = DONE;
                        end else begin
                            cur_addr_d = next_addr(cur_addr_q);
                        end
                    end else begin
                        data_d  = read_data_in;
                        addr_d  = cur_addr_q;
                        last_d  = final_beat;
                        valid_d = 1'b1;
                        state_d = SEND;
                    end
`else
                    data_d  = read_data_in;
                    addr_d  = cur_addr_q;
                    last_d  = (cur_addr_q == end_addr_q);
                    valid_d = 1'b1;
                    state_d = SEND;
`endif
                end
            end
            SEND: begin
                if (abort_in) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else if (valid_q && dump_ready_in) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        cur_addr_d = next_addr(cur_addr_q);
                        state_d    = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == READ) || (state_d == SEND);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            end_addr_q <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            end_addr_q <= end_addr_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign read_register_address_out = cur_addr_q;
    assign dump_valid_out            = valid_q;
    assign dump_data_out             = data_q;
    assign dump_address_out          = addr_q;
    assign dump_last_out             = last_q;
    assign busy_out                  = busy_q;
    assign done_out                  = done_q;

endmodule
